// File: rtl/fp_recip_pkg.sv
// Shared softmax definitions: reciprocal FSM states, input classification and
// the fixed-point constants used by the Newton-Raphson reciprocal.
package softmax_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        IT_A,
        IT_B,
        NORM,
        DONE
    } recip_state_t;

    typedef enum logic [1:0] {
        CASE_NORMAL,
        CASE_POW2,
        CASE_INF,
        CASE_ZERO
    } recip_case_t;

    typedef struct packed {
        recip_case_t kind;
        logic [7:0]  exp;
    } recip_class_t;

    localparam int          RECIP_ITERS = 3;
    localparam logic [31:0] SEED_C1     = 32'd3031741621;
    localparam logic [31:0] SEED_C2     = 32'd2021161081;
    localparam logic [31:0] TWO_Q30     = 32'h8000_0000;
    localparam int          EXP_BIAS    = 127;
    localparam logic [31:0] POS_INF     = 32'h7F80_0000;

    // Decides the output category and biased result exponent from |A|.
    // Denormal inputs count as zero; results below the normal range flush to zero.
    function automatic recip_class_t classify(input logic [30:0] mag);
        logic [7:0]   e;
        logic [22:0]  f;
        recip_class_t c;
        e      = mag[30:23];
        f      = mag[22:0];
        c.kind = CASE_ZERO;
        c.exp  = '0;
        if (e == 8'h00) begin
            c.kind = CASE_INF;
            c.exp  = POS_INF[30:23];
        end else if (e != 8'hFF) begin
            if (f == 23'h0) begin
                if (e != 8'(2 * EXP_BIAS)) begin
                    c.kind = CASE_POW2;
                    c.exp  = 8'(2 * EXP_BIAS) - e;
                end
            end else if (e < 8'(2 * EXP_BIAS - 1)) begin
                c.kind = CASE_NORMAL;
                c.exp  = 8'(2 * EXP_BIAS - 1) - e;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_recip_if.sv
// Valid/ready operand and result channels of the reciprocal unit.
interface fp_recip_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    modport master (
        output in_valid, A, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, A, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/fp_recip_umul.sv
// Combinational unsigned 32x32->64 multiplier, kept separate so it can be
// pipelined or mapped onto DSP blocks without touching the reciprocal FSM.
module umul32x32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = {32'h0, a} * {32'h0, b};
endmodule

// File: rtl/fp_recip.sv
// Iterative single-precision reciprocal: seed plus three Newton-Raphson steps on
// the mantissa through one shared multiplier, fixed 9-cycle latency.
module fp_recip
    import softmax_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    fp_recip_if.slave  bus
);

    localparam logic [1:0] LAST_ITER = 2'(RECIP_ITERS - 1);

    recip_state_t state, next_state;
    recip_class_t cls;
    logic [31:0]  a_reg, x_reg, t_reg, result_reg;
    logic [31:0]  mul_a, mul_b;
    logic [63:0]  prod;
    logic [23:0]  d_val;
    logic [22:0]  mant;
    logic [1:0]   iter_cnt;
    logic         unused_bits;

    assign d_val         = {1'b1, a_reg[22:0]};
    assign mant          = x_reg[31] ? 23'h7F_FFFF : x_reg[29:7];
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_reg;
    assign unused_bits   = ^{prod[63:62], prod[23:0], a_reg[30:23]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.in_valid) next_state = SEED;
            SEED:    next_state = IT_A;
            IT_A:    next_state = IT_B;
            IT_B:    next_state = (iter_cnt == LAST_ITER) ? NORM : IT_A;
            NORM:    next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand routing for the single shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            SEED: begin mul_a = SEED_C2;         mul_b = {8'h0, d_val};   end
            IT_A: begin mul_a = {8'h0, d_val};   mul_b = x_reg;           end
            IT_B: begin mul_a = x_reg;           mul_b = TWO_Q30 - t_reg; end
            default: ;
        endcase
    end

    umul32x32 u_mul (.a(mul_a), .b(mul_b), .p(prod));

    // x and t live in Q2.30; prod[55:24] and prod[61:30] are the truncated rescales.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            cls        <= '{kind: CASE_ZERO, exp: 8'h00};
            x_reg      <= '0;
            t_reg      <= '0;
            iter_cnt   <= '0;
            result_reg <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    a_reg    <= bus.A;
                    cls      <= classify(bus.A[30:0]);
                    iter_cnt <= '0;
                end
                SEED: x_reg <= SEED_C1 - prod[55:24];
                IT_A: t_reg <= prod[55:24];
                IT_B: begin
                    x_reg    <= prod[61:30];
                    iter_cnt <= iter_cnt + 2'd1;
                end
                NORM: begin
                    unique case (cls.kind)
                        CASE_NORMAL: result_reg <= {a_reg[31], cls.exp, mant};
                        CASE_POW2,
                        CASE_INF:    result_reg <= {a_reg[31], cls.exp, 23'h0};
                        default:     result_reg <= {a_reg[31], 31'h0};
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
